div_result_collector: RTL and testbench

//  Downstream stage of the 5-bit restoring divider. On each divide-complete pulse it

---
 rtl/div_result_collector.sv | 216 +++++++++++++++++++++
 tb/tb_div_result_collector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_collector.sv
// div_result_collector
// Downstream stage of the restoring divider. On each divide-complete pulse it
// steers the divider's shared result bus to read the quotient and then the
// remainder. It packs both with the zero/overflow flags into one record and
// queues the record in a small FIFO that drains over a valid/ready handshake.
module div_result_collector #(
   parameter int W     = 5,   // divider data width (quotient, remainder, bus)
   parameter int DEPTH = 4    // FIFO depth in records, power of 2, >= 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     div_done,
   input  logic                     div_zf,
   input  logic                     div_of,
   input  logic [W-1:0]             bus_data,
   output logic                     sel_out,
   output logic                     tri_en,
   output logic                     coll_ready,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [W-1:0]             m_quot,
   output logic [W-1:0]             m_rem,
   output logic                     m_zf,
   output logic                     m_of,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop_err,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD_Q = 2'd1,
      RD_R = 2'd2,
      PUSH = 2'd3
   } state_t;

   typedef struct packed {
      logic         zf;
      logic         of;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } rec_t;

   state_t          state_q;
   state_t          state_d;

   rec_t            rec_q;        // record being assembled
   rec_t            mem [DEPTH];  // FIFO storage
   rec_t            head;

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;

   logic            full;
   logic            accept;
   logic            drop;
   logic            push_en;
   logic            pop;

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------

   // A completion is taken only when idle with room for its record;
   // any other completion is lost and flagged.
   assign full    = (count_q == CW'(DEPTH));
   assign accept  = div_done && (state_q == IDLE) && !full;
   assign drop    = div_done && !accept;
   assign m_valid = (count_q != '0);
   assign pop     = m_valid && m_ready;
   assign count   = count_q;

   // ------------------------------------------------------------------
   // Read sequencer FSM
   // ------------------------------------------------------------------

   // State register; reset returns to IDLE at once, abandoning any partial read.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flagged results skip the bus reads, clean results read Q then R.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (div_zf || div_of) ? PUSH : RD_Q;
            end
         end
         RD_Q:    state_d = RD_R;
         RD_R:    state_d = PUSH;
         PUSH:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state only, so tri_en follows reset immediately.
   always_comb begin
      sel_out    = 1'b0;
      tri_en     = 1'b0;
      coll_ready = 1'b0;
      push_en    = 1'b0;
      case (state_q)
         IDLE: coll_ready = !full;
         RD_Q: begin
            sel_out = 1'b1;
            tri_en  = 1'b1;
         end
         RD_R: begin
            sel_out = 1'b0;
            tri_en  = 1'b1;
         end
         PUSH:    push_en = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Record assembly
   // ------------------------------------------------------------------

   // Flags latch with the accepted pulse; data fields fill from the bus in turn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rec_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  rec_q.zf <= div_zf;
                  rec_q.of <= div_of;
                  rec_q.q  <= '0;
                  rec_q.r  <= '0;
               end
            end
            RD_Q:    rec_q.q <= bus_data;
            RD_R:    rec_q.r <= bus_data;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Record FIFO
   // ------------------------------------------------------------------

   // Storage write in PUSH.
   // NOTE: the array is deliberately not reset; the head outputs are
   // gated by m_valid, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= rec_q;
      end
   end

   // Pointers wrap naturally at DEPTH; push and pop together leave occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_q + CW'(push_en) - CW'(pop);
      end
   end

   // Head record presented straight from storage, zero when the FIFO is empty.
   always_comb begin
      head   = mem[rd_ptr];
      m_quot = '0;
      m_rem  = '0;
      m_zf   = 1'b0;
      m_of   = 1'b0;
      if (m_valid) begin
         m_quot = head.q;
         m_rem  = head.r;
         m_zf   = head.zf;
         m_of   = head.of;
      end
   end

   // ------------------------------------------------------------------
   // Lost-completion flag
   // ------------------------------------------------------------------

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_err <= 1'b0;
      end else if (drop) begin
         drop_err <= 1'b1;
      end else if (clr_err) begin
         drop_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_result_collector.sv
// tb_div_result_collector
// Directed bench for div_result_collector. The bench models the divider side
// of the shared bus and keeps a queue of expected records that is checked as
// the consumer takes each record.
module tb_div_result_collector;

   localparam int W     = 5;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         zf;
      logic         of;
   } rec_t;

   logic                   clk;
   logic                   rst;
   logic                   div_done;
   logic                   div_zf;
   logic                   div_of;
   logic [W-1:0]           bus_data;
   logic                   sel_out;
   logic                   tri_en;
   logic                   coll_ready;
   logic                   m_valid;
   logic                   m_ready;
   logic [W-1:0]           m_quot;
   logic [W-1:0]           m_rem;
   logic                   m_zf;
   logic                   m_of;
   logic [$clog2(DEPTH):0] count;
   logic                   drop_err;
   logic                   clr_err;

   // Divider-side result registers driven onto the shared bus
   logic [W-1:0]           cur_q;
   logic [W-1:0]           cur_r;

   rec_t                   exp_q [$];
   int                     n_checks;
   int                     n_pass;

   div_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_done   (div_done),
      .div_zf     (div_zf),
      .div_of     (div_of),
      .bus_data   (bus_data),
      .sel_out    (sel_out),
      .tri_en     (tri_en),
      .coll_ready (coll_ready),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_quot     (m_quot),
      .m_rem      (m_rem),
      .m_zf       (m_zf),
      .m_of       (m_of),
      .count      (count),
      .drop_err   (drop_err),
      .clr_err    (clr_err)
   );

   // Divider bus driver: quotient when selected, remainder otherwise, idle low
   assign bus_data = tri_en ? (sel_out ? cur_q : cur_r) : '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance n rising edges, landing 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one divide-complete pulse; returns 1 unit after the sampling edge
   task automatic pulse(input logic zf, input logic of, input logic [W-1:0] q, input logic [W-1:0] r);
      cur_q    = q;
      cur_r    = r;
      div_zf   = zf;
      div_of   = of;
      div_done = 1'b1;
      tick(1);
      div_done = 1'b0;
      div_zf   = 1'b0;
      div_of   = 1'b0;
   endtask

   // Accepted clean operation, run until the FSM is back in IDLE
   task automatic clean_op(input logic [W-1:0] q, input logic [W-1:0] r);
      rec_t e;
      e = '{q: q, r: r, zf: 1'b0, of: 1'b0};
      exp_q.push_back(e);
      pulse(1'b0, 1'b0, q, r);
      tick(3);
   endtask

   // Consumer monitor: each handshake pops the scoreboard and compares the head
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            rec_t e;
            e = exp_q.pop_front();
            chk("m_quot", 32'(m_quot), 32'(e.q));
            chk("m_rem",  32'(m_rem),  32'(e.r));
            chk("m_zf",   32'(m_zf),   32'(e.zf));
            chk("m_of",   32'(m_of),   32'(e.of));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      div_done = 1'b0;
      div_zf   = 1'b0;
      div_of   = 1'b0;
      m_ready  = 1'b0;
      clr_err  = 1'b0;
      cur_q    = '0;
      cur_r    = '0;

      // Reset state
      tick(2);
      chk("rst_count",      32'(count),      32'd0);
      chk("rst_m_valid",    32'(m_valid),    32'd0);
      chk("rst_tri_en",     32'(tri_en),     32'd0);
      chk("rst_sel_out",    32'(sel_out),    32'd0);
      chk("rst_drop_err",   32'(drop_err),   32'd0);
      chk("rst_coll_ready", 32'(coll_ready), 32'd1);
      chk("rst_m_quot",     32'(m_quot),     32'd0);
      rst = 1'b0;
      tick(1);

      // Single clean operation: Q=3, R=2
      exp_q.push_back('{q: 5'd3, r: 5'd2, zf: 1'b0, of: 1'b0});
      pulse(1'b0, 1'b0, 5'd3, 5'd2);
      chk("s1_rdq_tri",   32'(tri_en),     32'd1);
      chk("s1_rdq_sel",   32'(sel_out),    32'd1);
      chk("s1_rdq_ready", 32'(coll_ready), 32'd0);
      tick(1);
      chk("s1_rdr_tri",   32'(tri_en),     32'd1);
      chk("s1_rdr_sel",   32'(sel_out),    32'd0);
      tick(1);
      chk("s1_push_tri",  32'(tri_en),     32'd0);
      chk("s1_push_vld",  32'(m_valid),    32'd0);
      tick(1);
      chk("s1_valid",     32'(m_valid),    32'd1);
      chk("s1_count",     32'(count),      32'd1);
      chk("s1_ready",     32'(coll_ready), 32'd1);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      chk("s1_drained",   32'(count),      32'd0);

      // Divide-by-zero: no bus read, record valid two cycles after the pulse
      exp_q.push_back('{q: 5'd0, r: 5'd0, zf: 1'b1, of: 1'b0});
      pulse(1'b1, 1'b0, 5'd7, 5'd9);
      chk("s2_no_tri",    32'(tri_en),     32'd0);
      chk("s2_not_yet",   32'(m_valid),    32'd0);
      tick(1);
      chk("s2_valid",     32'(m_valid),    32'd1);
      chk("s2_head_zf",   32'(m_zf),       32'd1);
      chk("s2_head_q",    32'(m_quot),     32'd0);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;

      // Overflow flag takes the same short path
      exp_q.push_back('{q: 5'd0, r: 5'd0, zf: 1'b0, of: 1'b1});
      pulse(1'b0, 1'b1, 5'd21, 5'd17);
      chk("s2o_no_tri",   32'(tri_en),     32'd0);
      tick(1);
      chk("s2o_valid",    32'(m_valid),    32'd1);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      chk("s2o_drained",  32'(count),      32'd0);

      // Fill to capacity, then lose a fifth completion
      for (int i = 1; i <= DEPTH; i++) begin
         clean_op(W'(i), W'(10 + i));
      end
      chk("s3_count_full", 32'(count),      32'd4);
      chk("s3_not_ready",  32'(coll_ready), 32'd0);
      pulse(1'b0, 1'b0, 5'd30, 5'd30);
      chk("s3_drop",       32'(drop_err),   32'd1);
      chk("s3_no_tri",     32'(tri_en),     32'd0);
      tick(3);
      chk("s3_count_hold", 32'(count),      32'd4);
      chk("s3_head_hold",  32'(m_quot),     32'd1);
      m_ready = 1'b1;
      tick(DEPTH);
      m_ready = 1'b0;
      chk("s3_empty",      32'(count),      32'd0);
      chk("s3_drop_stick", 32'(drop_err),   32'd1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      chk("s3_clr",        32'(drop_err),   32'd0);

      // Push and pop in the same cycle, across pointer wrap
      clean_op(5'd5, 5'd25);
      clean_op(5'd6, 5'd26);
      clean_op(5'd7, 5'd27);
      chk("s4_count3",     32'(count),      32'd3);
      exp_q.push_back('{q: 5'd8, r: 5'd28, zf: 1'b0, of: 1'b0});
      pulse(1'b0, 1'b0, 5'd8, 5'd28);
      tick(2);
      chk("s4_in_push",    32'(tri_en),     32'd0);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      chk("s4_count_same", 32'(count),      32'd3);
      chk("s4_head",       32'(m_quot),     32'd6);
      m_ready = 1'b1;
      tick(3);
      m_ready = 1'b0;
      chk("s4_empty",      32'(count),      32'd0);

      // Completion during RD_R is dropped; a clear in the same cycle loses to it
      exp_q.push_back('{q: 5'd9, r: 5'd1, zf: 1'b0, of: 1'b0});
      pulse(1'b0, 1'b0, 5'd9, 5'd1);
      tick(1);
      chk("s5_in_rdr",     32'(tri_en),     32'd1);
      div_done = 1'b1;
      clr_err  = 1'b1;
      tick(1);
      div_done = 1'b0;
      clr_err  = 1'b0;
      chk("s5_drop",       32'(drop_err),   32'd1);
      chk("s5_push_tri",   32'(tri_en),     32'd0);
      tick(1);
      chk("s5_count1",     32'(count),      32'd1);
      chk("s5_head_q",     32'(m_quot),     32'd9);
      chk("s5_head_r",     32'(m_rem),      32'd1);
      tick(4);
      chk("s5_one_rec",    32'(count),      32'd1);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      chk("s5_clr",        32'(drop_err),   32'd0);

      // Reset during RD_Q discards everything
      clean_op(5'd10, 5'd20);
      chk("s6_count1",     32'(count),      32'd1);
      pulse(1'b0, 1'b0, 5'd11, 5'd12);
      chk("s6_in_rdq",     32'(tri_en),     32'd1);
      rst = 1'b1;
      #1;
      chk("s6_rst_tri",    32'(tri_en),     32'd0);
      chk("s6_rst_count",  32'(count),      32'd0);
      chk("s6_rst_valid",  32'(m_valid),    32'd0);
      exp_q.delete();
      tick(1);
      rst = 1'b0;
      tick(1);

      // Operation after reset behaves like the first one
      exp_q.push_back('{q: 5'd13, r: 5'd14, zf: 1'b0, of: 1'b0});
      pulse(1'b0, 1'b0, 5'd13, 5'd14);
      chk("s6b_rdq_tri",   32'(tri_en),     32'd1);
      tick(2);
      chk("s6b_push_vld",  32'(m_valid),    32'd0);
      tick(1);
      chk("s6b_valid",     32'(m_valid),    32'd1);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      chk("s6b_empty",     32'(count),      32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
